// File: rtl/alu_ctrl_md_if.sv
// EX-stage bus between the pipeline and the ALU control / multiply-divide unit.
// The pipeline drives the instruction fields and operands, and the unit returns the select, stall and result.
interface alu_ctrl_md_if #(
   parameter int XLEN = 32
);
   logic            valid_in;
   logic            flush;
   logic [1:0]      ALUop;
   logic [6:0]      funct7;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [3:0]      ALUinput;
   logic            is_md;
   logic            illegal;
   logic            stall;
   logic            md_done;
   logic [XLEN-1:0] md_result;

   modport master (
      output valid_in, flush, ALUop, funct7, funct3, op_a, op_b,
      input  ALUinput, is_md, illegal, stall, md_done, md_result
   );

   modport slave (
      input  valid_in, flush, ALUop, funct7, funct3, op_a, op_b,
      output ALUinput, is_md, illegal, stall, md_done, md_result
   );
endinterface

// File: rtl/alu_ctrl_md.sv
// ALU select decode plus an optional iterative M-extension engine.
// The engine does shift-add multiply and restoring divide, one bit per cycle, and stalls EX until done.
module alu_ctrl_md #(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b1
) (
   input  logic           clk,
   input  logic           reset,
   alu_ctrl_md_if.slave   bus
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

   logic [3:0] alu_sel;
   logic       dec_ill;
   logic       dec_md;
   logic       shamt_ok;

   function automatic logic [3:0] base_code(input logic [2:0] f3);
      case (f3)
         3'b000:  return 4'b0010;
         3'b001:  return 4'b0100;
         3'b010:  return 4'b1000;
         3'b011:  return 4'b0111;
         3'b100:  return 4'b0011;
         3'b101:  return 4'b0101;
         3'b110:  return 4'b0001;
         default: return 4'b0000;
      endcase
   endfunction

   // For XLEN=32, funct7[0] would be shamt[5], which does not exist.
   assign shamt_ok = (XLEN == 64) || !bus.funct7[0];

   always_comb begin
      alu_sel = 4'b0010;
      dec_ill = 1'b1;
      dec_md  = 1'b0;
      case (bus.ALUop)
         2'b00: dec_ill = 1'b0;
         2'b01: begin
            case (bus.funct3)
               3'b000, 3'b001: begin alu_sel = 4'b0110; dec_ill = 1'b0; end
               3'b100, 3'b101: begin alu_sel = 4'b1000; dec_ill = 1'b0; end
               3'b110, 3'b111: begin alu_sel = 4'b0111; dec_ill = 1'b0; end
               default: ;
            endcase
         end
         2'b10: begin
            if (bus.funct7 == 7'b0000000) begin
               alu_sel = base_code(bus.funct3);
               dec_ill = 1'b0;
            end else if (bus.funct7 == 7'b0100000) begin
               if (bus.funct3 == 3'b000) begin alu_sel = 4'b0110; dec_ill = 1'b0; end
               if (bus.funct3 == 3'b101) begin alu_sel = 4'b1001; dec_ill = 1'b0; end
            end else if (bus.funct7 == 7'b0000001 && ENABLE_M) begin
               dec_md  = 1'b1;
               dec_ill = 1'b0;
            end
         end
         default: begin
            if (bus.funct3 == 3'b001) begin
               if (!bus.funct7[5] && shamt_ok) begin alu_sel = 4'b0100; dec_ill = 1'b0; end
            end else if (bus.funct3 == 3'b101) begin
               if (shamt_ok) begin
                  alu_sel = bus.funct7[5] ? 4'b1001 : 4'b0101;
                  dec_ill = 1'b0;
               end
            end else begin
               alu_sel = base_code(bus.funct3);
               dec_ill = 1'b0;
            end
         end
      endcase
   end

   assign bus.ALUinput = alu_sel;
   assign bus.illegal  = dec_ill;
   assign bus.is_md    = dec_md;

   generate
      if (ENABLE_M) begin : g_md
         state_e                state_q, state_d;
         logic [CW-1:0]         cnt_q, cnt_d;
         logic [2*XLEN-1:0]     acc_q, acc_d;
         logic [XLEN-1:0]       opnd_q, opnd_d;
         logic                  neg_q, neg_d, neg_rem_q, neg_rem_d;
         logic [1:0]            fn_q, fn_d;
         logic                  md_done_q, md_done_d;
         logic [XLEN-1:0]       md_result_q, md_result_d;
         logic                  stall_c;
         logic                  a_sgn, b_sgn, a_neg, b_neg;
         logic [XLEN-1:0]       a_mag, b_mag;
         logic [XLEN:0]         mul_sum, div_sh, div_diff;
         logic [2*XLEN-1:0]     mul_n, div_n, prod;
         logic [XLEN-1:0]       quo, rem;

         always_comb begin
            a_sgn = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
            b_sgn = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
            a_neg = a_sgn & bus.op_a[XLEN-1];
            b_neg = b_sgn & bus.op_b[XLEN-1];
            a_mag = a_neg ? -bus.op_a : bus.op_a;
            b_mag = b_neg ? -bus.op_b : bus.op_b;
            // acc holds {high product, multiplier} for MUL and {remainder, quotient} for DIV
            mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
            mul_n    = {mul_sum, acc_q[XLEN-1:1]};
            div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
            div_diff = div_sh - {1'b0, opnd_q};
            div_n    = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            prod = neg_q ? -mul_n : mul_n;
            quo  = neg_q ? -div_n[XLEN-1:0] : div_n[XLEN-1:0];
            rem  = neg_rem_q ? -div_n[2*XLEN-1:XLEN] : div_n[2*XLEN-1:XLEN];
         end

         always_comb begin
            state_d     = state_q;
            cnt_d       = cnt_q;
            acc_d       = acc_q;
            opnd_d      = opnd_q;
            neg_d       = neg_q;
            neg_rem_d   = neg_rem_q;
            fn_d        = fn_q;
            md_done_d   = 1'b0;
            md_result_d = md_result_q;
            stall_c     = 1'b0;
            case (state_q)
               IDLE: begin
                  if (bus.valid_in && dec_md && !bus.flush) begin
                     stall_c   = 1'b1;
                     acc_d     = {{XLEN{1'b0}}, a_mag};
                     opnd_d    = b_mag;
                     // Divide-by-zero quotient stays all ones, so suppress its sign fix-up.
                     neg_d     = (a_neg ^ b_neg) & (!bus.funct3[2] || (bus.op_b != '0));
                     neg_rem_d = a_neg;
                     fn_d      = bus.funct3[1:0];
                     cnt_d     = CW'(XLEN - 1);
                     state_d   = bus.funct3[2] ? DIV : MUL;
                  end
               end
               MUL, DIV: begin
                  if (bus.flush) begin
                     state_d = IDLE;
                  end else begin
                     stall_c = 1'b1;
                     acc_d   = (state_q == MUL) ? mul_n : div_n;
                     cnt_d   = cnt_q - 1'b1;
                     if (cnt_q == '0) begin
                        if (state_q == MUL)
                           md_result_d = (fn_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                        else
                           md_result_d = fn_q[1] ? rem : quo;
                        md_done_d = 1'b1;
                        state_d   = DONE;
                     end
                  end
               end
               default: state_d = IDLE;
            endcase
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               state_q     <= IDLE;
               cnt_q       <= '0;
               acc_q       <= '0;
               opnd_q      <= '0;
               neg_q       <= 1'b0;
               neg_rem_q   <= 1'b0;
               fn_q        <= '0;
               md_done_q   <= 1'b0;
               md_result_q <= '0;
            end else begin
               state_q     <= state_d;
               cnt_q       <= cnt_d;
               acc_q       <= acc_d;
               opnd_q      <= opnd_d;
               neg_q       <= neg_d;
               neg_rem_q   <= neg_rem_d;
               fn_q        <= fn_d;
               md_done_q   <= md_done_d;
               md_result_q <= md_result_d;
            end
         end

         assign bus.stall     = stall_c;
         assign bus.md_done   = md_done_q;
         assign bus.md_result = md_result_q;
      end else begin : g_no_md
         assign bus.stall     = 1'b0;
         assign bus.md_done   = 1'b0;
         assign bus.md_result = '0;
      end
   endgenerate
endmodule
